// File: rtl/adc_captura.sv
// adc_captura: dual-channel 14-bit ADC conversion and serial readout.
// Waits for a start request, pulses ad_conv for CONV_TICKS pacing ticks,
// clocks 34 bits out of the ADC on adc_sck (one half-period per
// clock_enable tick), then presents both channel samples with a one-clock
// sample_valid strobe. A start that arrives while busy is dropped and
// latched in the sticky overrun flag.
module adc_captura #(
  parameter int CONV_TICKS = 1,
  parameter int DATA_W     = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clock_enable,
  input  logic              start,
  input  logic              spi_miso,
  output logic              ad_conv,
  output logic              adc_sck,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] ch0_data,
  output logic [DATA_W-1:0] ch1_data,
  output logic              overrun
);

  localparam int                FRAME_W   = 34;
  localparam int                TICK_W    = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CONV_TICKS - 1);
  localparam logic [5:0]        LAST_BIT  = 6'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_pending;
  logic                r_busy;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [5:0]          r_bit_cnt;
  logic                r_phase;
  // The first frame bit is always discarded, so only the 33 most recent
  // bits are kept; index k still holds the bit that lands in frame bit k.
  logic [FRAME_W-2:0]  r_sr;
  logic                r_ad_conv;
  logic                r_adc_sck;
  logic                r_sample_valid;
  logic [DATA_W-1:0]   r_ch0_data;
  logic [DATA_W-1:0]   r_ch1_data;
  logic                r_overrun;

  // A request is live if one is already pending or a fresh start arrives
  // while the block is not busy (the sample_valid cycle still counts as busy).
  logic w_req;
  assign w_req = r_pending | (start & ~r_busy);

  // Frame sequencer: request capture, conversion pulse, serial shift, hand-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pending      <= 1'b0;
      r_busy         <= 1'b0;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_phase        <= 1'b0;
      r_sr           <= '0;
      r_ad_conv      <= 1'b0;
      r_adc_sck      <= 1'b0;
      r_sample_valid <= 1'b0;
      r_ch0_data     <= '0;
      r_ch1_data     <= '0;
      r_overrun      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the register values from before this edge; the default below makes
      // sample_valid a single-clock pulse unless DONE overrides it.
      r_sample_valid <= 1'b0;

      if (start && r_busy) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_req && clock_enable) begin
            r_state    <= S_CONV;
            r_ad_conv  <= 1'b1;
            r_tick_cnt <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            // Busy drops here the clock after sample_valid unless a request waits.
            r_pending <= w_req;
            r_busy    <= w_req;
          end
        end

        S_CONV: begin
          if (clock_enable) begin
            if (r_tick_cnt == LAST_TICK) begin
              r_ad_conv <= 1'b0;
              r_state   <= S_SHIFT;
              r_bit_cnt <= '0;
              r_phase   <= 1'b0;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (clock_enable) begin
            if (!r_phase) begin
              // Rising edge of adc_sck: capture the bit the ADC presented.
              r_adc_sck <= 1'b1;
              r_sr      <= {r_sr[FRAME_W-3:0], spi_miso};
              r_phase   <= 1'b1;
            end else begin
              r_adc_sck <= 1'b0;
              r_phase   <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          r_ch0_data     <= r_sr[31:18];
          r_ch1_data     <= r_sr[15:2];
          r_sample_valid <= 1'b1;
          r_state        <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ad_conv      = r_ad_conv;
  assign adc_sck      = r_adc_sck;
  assign busy         = r_busy;
  assign sample_valid = r_sample_valid;
  assign ch0_data     = r_ch0_data;
  assign ch1_data     = r_ch1_data;
  assign overrun      = r_overrun;

endmodule

// File: doc/adc_captura.md
Name: adc_captura

Overview:
- Downstream neighbour of the preamplifier SPI driver.
- Once the preamp gain is loaded, this block runs the dual-channel 14-bit ADC conversion/readout cycle: it pulses ad_conv, clocks 34 serial bits out of the ADC, and presents both channel samples (two's complement) with a one-cycle valid strobe.
- It paces its serial clock from the same clock_enable tick used by the preamp driver.

Parameters:
- CONV_TICKS, 1: number of clock_enable ticks ad_conv is held high.
- DATA_W, 14: sample width per channel. Fixed frame layout; only 14 is supported.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clock_enable  input  1  pacing tick; one serial half-period per tick.
- start  input  1  request one conversion; sampled every clock.
- spi_miso  input  1  serial data from ADC.
- ad_conv  output  1  conversion strobe to ADC, registered.
- adc_sck  output  1  serial clock to ADC, registered (not gated clock).
- busy  output  1  high while a request is pending or a frame is in progress.
- sample_valid  output  1  one-clock pulse when ch0_data/ch1_data update.
- ch0_data  output  DATA_W  channel 0 sample, held until next valid.
- ch1_data  output  DATA_W  channel 1 sample, held until next valid.
- overrun  output  1  sticky: start seen while busy.

Behaviour:
- Reset values: ad_conv=0, adc_sck=0, busy=0, sample_valid=0, ch0_data=0, ch1_data=0, overrun=0.
- Reset clears the shift register, counters and pending flag; state returns to IDLE.
- Reset mid-frame aborts the frame immediately with no valid pulse; the ADC resynchronises on the next ad_conv.
- States: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - start=1 sets pending.
  - On the first clock_enable tick with pending=1, go to CONV: ad_conv<=1, tick counter<=0, pending<=0.
  - If start and clock_enable arrive in the same cycle, the tick is used (CONV entered that cycle).
- CONV:
  - ad_conv stays high for CONV_TICKS enable ticks.
  - On the last tick: ad_conv<=0, go to SHIFT, bit_cnt<=0, phase<=0.
- SHIFT, on each enable tick:
  - phase=0: adc_sck<=1; sr<={sr[32:0],spi_miso}; phase<=1.
  - phase=1: adc_sck<=0; phase<=0; bit_cnt<=bit_cnt+1.
  - On phase=1 with bit_cnt=33, go to DONE.
- Frame layout: 34-bit sr, first received bit lands in sr[33].
  - sr[33:32] ignored.
  - sr[31:18] = ch0, MSB first.
  - sr[17:16] ignored.
  - sr[15:2] = ch1, MSB first.
  - sr[1:0] ignored.
- DONE, one clock regardless of clock_enable: ch0_data<=sr[31:18], ch1_data<=sr[15:2], sample_valid<=1, return to IDLE.
  - sample_valid is high for exactly one clock.
- Latency, from the enable tick entering CONV to sample_valid: CONV_TICKS+68 enable ticks, plus 1 clock.
- Serial clock shape: adc_sck idle low; exactly 34 rising edges per frame; adc_sck=0 outside SHIFT.
- busy = pending or state!=IDLE. It rises the clock after start and falls the clock after sample_valid.
- Back-to-back: start in the same cycle as sample_valid (state DONE) counts as busy.
  - The request is not queued; overrun<=1.
- Start while busy: ignored, overrun set, overrun cleared only by reset. The frame in progress is unaffected.
- clock_enable low: the FSM freezes in CONV/SHIFT with outputs held.

Test Plan:
- Reset then idle: with clock_enable every 4 clocks and no start → all outputs 0, adc_sck never toggles for 200 clocks.
- Single frame: start pulse, ADC model drives ch0=14'h2001, ch1=14'h1FFE, idle bits=1 → ad_conv high 1 tick, exactly 34 adc_sck rising edges, sample_valid one clock, ch0_data=14'h2001, ch1_data=14'h1FFE, busy low next clock.
- Latency check: CONV_TICKS=3, enable every 2 clocks → sample_valid exactly (3+68)*2+1 clocks after the CONV-entry tick; ad_conv high 6 clocks.
- Overrun: second start at shift bit 10 → frame completes with the first data, no second frame, overrun=1 sticky until reset.
- Reset mid-frame: assert reset at bit 20 → next clock adc_sck=0, ad_conv=0, busy=0, ch*_data=0, no sample_valid; a fresh start yields a correct frame (ch0=14'h0555, ch1=14'h3AAA).
- Enable stall: clock_enable held low for 50 clocks mid-SHIFT → adc_sck and bit count frozen; the frame finishes with correct data after enable resumes.
